// File: rtl/seq_addsub_if.sv
// Operand/result handshake bundle for seq_addsub.
// master drives operands and out_ready; slave is the adder/subtractor.
interface seq_addsub_if #(
  parameter int WIDTH = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, x, y, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, x, y, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/seq_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB first,
// registered carry, valid/ready on both sides, one op in flight.
module seq_addsub #(
  parameter int WIDTH = 5,
  parameter int DIGIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_addsub_if.slave io
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad
      $error("seq_addsub: illegal WIDTH/DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t nstate;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] s_q;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   sl;
  logic             msb_cin;
  logic             last;

  assign sl = {1'b0, a[DIGIT-1:0]}
            + {1'b0, b[DIGIT-1:0]}
            + {{DIGIT{1'b0}}, carry};

  // carry into the slice MSB recovered from its sum bit
  assign msb_cin = a[DIGIT-1] ^ b[DIGIT-1] ^ sl[DIGIT-1];

  assign acc_nxt = (acc >> DIGIT)
                 | (WIDTH'(sl[DIGIT-1:0]) << (WIDTH - DIGIT));

  assign last = (cnt == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (io.in_valid)  nstate = RUN;
      RUN:     if (last)         nstate = DONE;
      DONE:    if (io.out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      s_q    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.in_valid) begin
            a     <= io.x;
            b     <= io.sub ? ~io.y : io.y;
            carry <= io.sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          a     <= a >> DIGIT;
          b     <= b >> DIGIT;
          carry <= sl[DIGIT];
          acc   <= acc_nxt;
          cnt   <= cnt + CW'(1);
          if (last) begin
            s_q    <= acc_nxt;
            cout_q <= sl[DIGIT];
            ovf_q  <= msb_cin ^ sl[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.s         = s_q;
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed and table-driven bench for seq_addsub,
// WIDTH=5/DIGIT=1 and WIDTH=8/DIGIT=4 instances.
module tb_seq_addsub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_addsub_if #(.WIDTH(5)) i5 ();
  seq_addsub_if #(.WIDTH(8)) i8 ();

  seq_addsub #(.WIDTH(5), .DIGIT(1)) u5 (
    .clk(clk), .rst_n(rst_n), .io(i5.slave)
  );
  seq_addsub #(.WIDTH(8), .DIGIT(4)) u8 (
    .clk(clk), .rst_n(rst_n), .io(i8.slave)
  );

  typedef struct {
    logic [4:0] x;
    logic [4:0] y;
    logic       sub;
    logic [4:0] s;
    logic       cout;
    logic       ovf;
  } vec5_t;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       sub;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec8_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ref8(input logic [7:0] x,
                                      input logic [7:0] y,
                                      input logic sub);
    logic [8:0] f;
    logic [7:0] yy;
    logic       o;
    yy = sub ? ~y : y;
    f  = {1'b0, x} + {1'b0, yy} + {8'd0, sub};
    if (sub) o = (x[7] != y[7]) && (f[7] != x[7]);
    else     o = (x[7] == y[7]) && (f[7] != x[7]);
    return {f[7:0], f[8], o};
  endfunction

  task automatic op5(input logic [4:0] x, input logic [4:0] y,
                     input logic sub, output logic [4:0] s,
                     output logic c, output logic o, output int lat);
    int n = 0;
    while (!i5.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    i5.x = x; i5.y = y; i5.sub = sub; i5.in_valid = 1'b1;
    @(posedge clk); #1;
    i5.in_valid = 1'b0; i5.x = ~x; i5.y = ~y; i5.sub = ~sub;
    lat = 0;
    while (!i5.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    s = i5.s; c = i5.cout; o = i5.ovf;
    i5.out_ready = 1'b1;
    @(posedge clk); #1;
    i5.out_ready = 1'b0;
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y,
                     input logic sub, output logic [7:0] s,
                     output logic c, output logic o, output int lat);
    int n = 0;
    while (!i8.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    i8.x = x; i8.y = y; i8.sub = sub; i8.in_valid = 1'b1;
    @(posedge clk); #1;
    i8.in_valid = 1'b0; i8.x = ~x; i8.y = ~y; i8.sub = ~sub;
    lat = 0;
    while (!i8.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    s = i8.s; c = i8.cout; o = i8.ovf;
    i8.out_ready = 1'b1;
    @(posedge clk); #1;
    i8.out_ready = 1'b0;
  endtask

  vec5_t t5[10];
  vec8_t t8[3];

  initial begin
    logic [4:0] s5;
    logic [7:0] s8;
    logic       c;
    logic       o;
    logic [9:0] r;
    int         lat;
    int         seen;

    t5[0] = '{5'd13, 5'd9,  1'b0, 5'd22, 1'b0, 1'b1};
    t5[1] = '{5'd31, 5'd1,  1'b0, 5'd0,  1'b1, 1'b0};
    t5[2] = '{5'd5,  5'd9,  1'b1, 5'd28, 1'b0, 1'b0};
    t5[3] = '{5'd9,  5'd5,  1'b1, 5'd4,  1'b1, 1'b0};
    t5[4] = '{5'd0,  5'd16, 1'b1, 5'd16, 1'b0, 1'b1};
    t5[5] = '{5'd15, 5'd1,  1'b0, 5'd16, 1'b0, 1'b1};
    t5[6] = '{5'd16, 5'd16, 1'b0, 5'd0,  1'b1, 1'b1};
    t5[7] = '{5'd7,  5'd7,  1'b1, 5'd0,  1'b1, 1'b0};
    t5[8] = '{5'd0,  5'd1,  1'b1, 5'd31, 1'b0, 1'b0};
    t5[9] = '{5'd16, 5'd1,  1'b1, 5'd15, 1'b1, 1'b1};

    t8[0] = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};
    t8[1] = '{8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1};
    t8[2] = '{8'd100, 8'd200, 1'b1, 8'd156, 1'b0, 1'b1};

    i5.in_valid = 0; i5.x = 0; i5.y = 0; i5.sub = 0; i5.out_ready = 0;
    i8.in_valid = 0; i8.x = 0; i8.y = 0; i8.sub = 0; i8.out_ready = 0;

    rst_n = 1'b0;
    #1;
    chk("reset5", {i5.in_ready, i5.out_valid, i5.cout, i5.ovf, i5.s},
        {4'b1000, 5'd0});
    chk("reset8", {i8.in_ready, i8.out_valid, i8.cout, i8.ovf, i8.s},
        {4'b1000, 8'd0});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      op5(t5[i].x, t5[i].y, t5[i].sub, s5, c, o, lat);
      chk($sformatf("v5_%0d", i), {s5, c, o},
          {t5[i].s, t5[i].cout, t5[i].ovf});
      chk($sformatf("lat5_%0d", i), lat, 5);
    end

    // backpressure: result holds, extra in_valid ignored
    i5.x = 5'd3; i5.y = 5'd4; i5.sub = 1'b0; i5.in_valid = 1'b1;
    @(posedge clk); #1;
    i5.in_valid = 1'b0;
    chk("run_busy", i5.in_ready, 1'b0);
    lat = 0;
    while (!i5.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_lat", lat, 5);
    for (int k = 0; k < 10; k++) begin
      i5.in_valid = 1'b1; i5.x = 5'(k); i5.y = 5'd20; i5.sub = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp_hold_%0d", k),
          {i5.out_valid, i5.in_ready, i5.cout, i5.ovf, i5.s},
          {4'b1000, 5'd7});
    end
    i5.in_valid = 1'b0;
    i5.out_ready = 1'b1;
    @(posedge clk); #1;
    i5.out_ready = 1'b0;
    chk("bp_take", {i5.out_valid, i5.in_ready}, 2'b01);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (i5.out_valid || !i5.in_ready) seen++;
    end
    chk("bp_noqueue", seen, 0);
    chk("bp_shold", i5.s, 5'd7);

    // reset after two RUN edges
    i5.x = 5'd13; i5.y = 5'd9; i5.sub = 1'b0; i5.in_valid = 1'b1;
    @(posedge clk); #1;
    i5.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst", {i5.in_ready, i5.out_valid, i5.cout, i5.ovf, i5.s},
        {4'b1000, 5'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (i5.out_valid) seen++;
    end
    chk("midrst_quiet", seen, 0);
    op5(5'd31, 5'd1, 1'b0, s5, c, o, lat);
    chk("recover", {s5, c, o}, {5'd0, 1'b1, 1'b0});

    for (int i = 0; i < 3; i++) begin
      op8(t8[i].x, t8[i].y, t8[i].sub, s8, c, o, lat);
      chk($sformatf("v8_%0d", i), {s8, c, o},
          {t8[i].s, t8[i].cout, t8[i].ovf});
      chk($sformatf("lat8_%0d", i), lat, 2);
    end

    for (int i = 0; i < 24; i++) begin
      logic [7:0] rx;
      logic [7:0] ry;
      logic       rs;
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      r  = ref8(rx, ry, rs);
      op8(rx, ry, rs, s8, c, o, lat);
      chk($sformatf("rnd8_%0d", i), {s8, c, o}, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
